// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: parks incoming notes in the lowest free voice slot
// and counts each voice's duration down in beats, releasing the slot on expiry.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         beat,
  input  logic                         new_note,
  input  logic [NOTE_W-1:0]            note,
  input  logic [DUR_W-1:0]             duration,
  output logic                         player_available,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic                         note_dropped
);

  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  logic [NUM_VOICES-1:0]             active_q, active_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
  logic [NUM_VOICES-1:0][DUR_W-1:0]  remaining_q, remaining_d;
  logic [NUM_VOICES-1:0]             voice_load_q, voice_load_d;
  logic                              note_dropped_q, note_dropped_d;

  logic [NUM_VOICES-1:0] alloc_oh;
  logic                  free_found;
  logic                  tick;
  logic                  accept;

  assign tick   = beat & play;
  assign accept = new_note && (note != '0) && (duration != '0);

  always_comb begin
    active_d       = active_q;
    note_d         = note_q;
    remaining_d    = remaining_q;
    voice_load_d   = '0;
    note_dropped_d = 1'b0;
    alloc_oh       = '0;
    free_found     = 1'b0;

    // Allocation looks at registered state only, so a voice releasing this
    // cycle still counts as busy.
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!active_q[i] && !free_found) begin
        alloc_oh[i] = 1'b1;
        free_found  = 1'b1;
      end
    end

    for (int i = 0; i < NUM_VOICES; i++) begin
      if (active_q[i] && tick) begin
        if (remaining_q[i] == DUR_ONE) begin
          active_d[i]    = 1'b0;
          note_d[i]      = '0;
          remaining_d[i] = '0;
        end else begin
          remaining_d[i] = remaining_q[i] - DUR_ONE;
        end
      end
    end

    // The chosen slot was idle, so loading it never collides with a decrement.
    if (accept) begin
      if (free_found) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (alloc_oh[i]) begin
            active_d[i]     = 1'b1;
            note_d[i]       = note;
            remaining_d[i]  = duration;
            voice_load_d[i] = 1'b1;
          end
        end
      end else begin
        note_dropped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q       <= '0;
      note_q         <= '0;
      remaining_q    <= '0;
      voice_load_q   <= '0;
      note_dropped_q <= 1'b0;
    end else begin
      active_q       <= active_d;
      note_q         <= note_d;
      remaining_q    <= remaining_d;
      voice_load_q   <= voice_load_d;
      note_dropped_q <= note_dropped_d;
    end
  end

  assign player_available = ~reset & ~(&active_q);
  assign voice_active     = active_q;
  assign voice_note       = note_q;
  assign voice_load       = voice_load_q;
  assign note_dropped     = note_dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random
// traffic, all compared against an array-based model of the voice rules.
module tb_voice_allocator;

  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic             clk = 1'b0;
  logic             reset, play, beat, new_note;
  logic [NW-1:0]    note;
  logic [DW-1:0]    duration;
  logic             player_available;
  logic [NV-1:0]    voice_active;
  logic [NV*NW-1:0] voice_note;
  logic [NV-1:0]    voice_load;
  logic             note_dropped;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
    .clk(clk), .reset(reset), .play(play), .beat(beat), .new_note(new_note),
    .note(note), .duration(duration), .player_available(player_available),
    .voice_active(voice_active), .voice_note(voice_note),
    .voice_load(voice_load), .note_dropped(note_dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_act[NV];
  int m_note[NV];
  int m_rem[NV];
  int m_load[NV];
  int m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next-state of the model for one clock edge.
  task automatic model_step(input int r, p, b, nn, nt, d);
    int free_idx;
    free_idx = -1;
    for (int i = 0; i < NV; i++) m_load[i] = 0;
    m_drop = 0;
    if (r != 0) begin
      for (int i = 0; i < NV; i++) begin
        m_act[i] = 0; m_note[i] = 0; m_rem[i] = 0;
      end
      return;
    end
    for (int i = NV - 1; i >= 0; i--) if (m_act[i] == 0) free_idx = i;
    if (b != 0 && p != 0) begin
      for (int i = 0; i < NV; i++) begin
        if (m_act[i] != 0) begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            m_act[i] = 0; m_note[i] = 0;
          end
        end
      end
    end
    if (nn != 0 && nt != 0 && d != 0) begin
      if (free_idx >= 0) begin
        m_act[free_idx] = 1; m_note[free_idx] = nt; m_rem[free_idx] = d;
        m_load[free_idx] = 1;
      end else begin
        m_drop = 1;
      end
    end
  endtask

  // One clock: drive inputs, check combinational availability, step model,
  // then compare every registered output after the edge.
  task automatic cycle(input int r, p, b, nn, nt, d);
    logic [NV-1:0]    e_act, e_load;
    logic [NV*NW-1:0] e_note;
    int any_free;
    @(negedge clk);
    reset = r[0]; play = p[0]; beat = b[0]; new_note = nn[0];
    note = NW'(nt); duration = DW'(d);
    any_free = 0;
    for (int i = 0; i < NV; i++) if (m_act[i] == 0) any_free = 1;
    #1 check("player_available", 32'(player_available), 32'((r == 0) && (any_free != 0)));
    model_step(r, p, b, nn, nt, d);
    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      e_act[i]  = (m_act[i] != 0);
      e_load[i] = (m_load[i] != 0);
      e_note[i*NW +: NW] = NW'(m_note[i]);
    end
    check("voice_active", 32'(voice_active), 32'(e_act));
    check("voice_note", 32'(voice_note), 32'(e_note));
    check("voice_load", 32'(voice_load), 32'(e_load));
    check("note_dropped", 32'(note_dropped), 32'(m_drop != 0));
  endtask

  task automatic idle(input int n, input int p);
    for (int k = 0; k < n; k++) cycle(0, p, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; beat = 1'b0; new_note = 1'b0;
    note = '0; duration = '0;
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_rem[i] = 0; m_load[i] = 0;
    end
    m_drop = 0;

    // Reset release
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("reset_active", 32'(voice_active), 32'd0);
    check("reset_avail", 32'(player_available), 32'd0);
    idle(1, 1);
    check("avail_after_reset", 32'(player_available), 32'd1);

    // Single note, three beats four cycles apart
    cycle(0, 1, 0, 1, 40, 3);
    check("single_load", 32'(voice_load), 32'b001);
    check("single_note", 32'(voice_note[5:0]), 32'd40);
    for (int k = 0; k < 3; k++) begin
      idle(3, 1);
      cycle(0, 1, 1, 0, 0, 0);
    end
    check("single_release", 32'(voice_active), 32'b000);
    check("single_note_clr", 32'(voice_note[5:0]), 32'd0);

    // Fill all voices then overflow
    cycle(0, 1, 0, 1, 10, 4);
    cycle(0, 1, 0, 1, 20, 4);
    cycle(0, 1, 0, 1, 30, 4);
    check("fill_active", 32'(voice_active), 32'b111);
    check("fill_avail", 32'(player_available), 32'd0);
    cycle(0, 1, 0, 1, 50, 4);
    check("overflow_drop", 32'(note_dropped), 32'd1);
    check("overflow_notes", 32'(voice_note), 32'({6'd30, 6'd20, 6'd10}));
    idle(1, 1);
    check("overflow_drop_end", 32'(note_dropped), 32'd0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 1, 0, 0, 0);
    check("fill_drain", 32'(voice_active), 32'b000);

    // Pause freezes countdown
    cycle(0, 1, 0, 1, 12, 2);
    for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0, 0, 0);
    check("pause_hold", 32'(voice_active), 32'b001);
    cycle(0, 1, 1, 0, 0, 0);
    check("pause_beat1", 32'(voice_active), 32'b001);
    cycle(0, 1, 1, 0, 0, 0);
    check("pause_beat2", 32'(voice_active), 32'b000);

    // Voice 1 expiring in the same cycle as new_note: still dropped
    cycle(0, 1, 0, 1, 5, 5);
    cycle(0, 1, 0, 1, 6, 1);
    cycle(0, 1, 0, 1, 7, 5);
    cycle(0, 1, 1, 1, 8, 3);
    check("simul_drop", 32'(note_dropped), 32'd1);
    check("simul_active", 32'(voice_active), 32'b101);
    // Load on a beat cycle with duration 1 survives that beat
    cycle(0, 1, 1, 1, 9, 1);
    check("beatload_active", 32'(voice_active), 32'b111);
    check("beatload_load", 32'(voice_load), 32'b010);
    idle(2, 1);
    check("beatload_hold", 32'(voice_active[1]), 32'd1);
    cycle(0, 1, 1, 0, 0, 0);
    check("beatload_release", 32'(voice_active[1]), 32'd0);

    // Rest and zero duration allocate nothing
    cycle(0, 1, 0, 1, 0, 4);
    check("rest_load", 32'(voice_load), 32'd0);
    cycle(0, 1, 0, 1, 33, 0);
    check("zero_dur_load", 32'(voice_load), 32'd0);

    // Reset mid-note
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 11, 9);
    cycle(0, 1, 0, 1, 22, 9);
    check("pre_reset_active", 32'(voice_active), 32'b011);
    cycle(1, 1, 1, 1, 33, 9);
    check("mid_reset_active", 32'(voice_active), 32'b000);
    check("mid_reset_note", 32'(voice_note), 32'd0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      int r, p, b, nn, nt, d;
      r  = ($urandom_range(99, 0) == 0) ? 1 : 0;
      p  = ($urandom_range(3, 0) != 0) ? 1 : 0;
      b  = ($urandom_range(2, 0) == 0) ? 1 : 0;
      nn = ($urandom_range(2, 0) == 0) ? 1 : 0;
      nt = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(63, 1));
      d  = ($urandom_range(15, 0) == 0) ? int'($urandom_range(63, 0)) : int'($urandom_range(5, 0));
      cycle(r, p, b, nn, nt, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
